// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 32-bit words
// to instruction memory and releases the core's reset on a valid checksum.
module prog_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_RUN,
      S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_n;
   logic [15:0] r_word_cnt;
   logic [1:0]  r_byte_cnt;
   logic [7:0]  r_xor;
   logic [23:0] r_asm;

   logic        w_accept;
   logic        w_word_done;
   logic        w_last_word;
   logic [15:0] w_n;

   assign in_ready = (r_state != S_RUN) && (r_state != S_ERR);

   // Handshake and word-boundary decode
   always_comb begin
      w_accept    = in_valid & in_ready;
      w_n         = {in_data, r_n[7:0]};
      w_word_done = w_accept && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
      w_last_word = (17'(r_word_cnt) + 17'd1) == 17'(r_n);
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_HDR0;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_HDR0: if (w_accept) w_next = S_HDR1;
         S_HDR1: begin
            if (w_accept) begin
               if (32'(w_n) > DEPTH)   w_next = S_ERR;
               else if (w_n == 16'd0) w_next = S_CSUM;
               else                   w_next = S_DATA;
            end
         end
         S_DATA: if (w_word_done && w_last_word) w_next = S_CSUM;
         S_CSUM: if (w_accept) w_next = (in_data == r_xor) ? S_RUN : S_ERR;
         S_RUN:  if (reload) w_next = S_HDR0;
         S_ERR:  if (reload) w_next = S_HDR0;
         default: w_next = S_HDR0;
      endcase
   end

   // Datapath: header capture, word assembly, checksum and registered status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n        <= 16'd0;
         r_word_cnt <= 16'd0;
         r_byte_cnt <= 2'd0;
         r_xor      <= 8'd0;
         r_asm      <= 24'd0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         cpu_rst <= (w_next != S_RUN);
         done    <= (w_next == S_RUN);
         err     <= (w_next == S_ERR);
         unique case (r_state)
            S_HDR0: begin
               if (w_accept) begin
                  r_n[7:0]   <= in_data;
                  r_xor      <= in_data;
                  r_byte_cnt <= 2'd0;
                  r_word_cnt <= 16'd0;
               end
            end
            S_HDR1: begin
               if (w_accept) begin
                  r_n[15:8] <= in_data;
                  r_xor     <= r_xor ^ in_data;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_xor      <= r_xor ^ in_data;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_asm      <= {in_data, r_asm[23:8]};
                  if (r_byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= r_word_cnt[ADDR_W-1:0];
                     imem_wdata <= {in_data, r_asm};
                     r_word_cnt <= r_word_cnt + 16'd1;
                  end
               end
            end
            S_RUN, S_ERR: begin
               if (reload) begin
                  r_n        <= 16'd0;
                  r_word_cnt <= 16'd0;
                  r_byte_cnt <= 2'd0;
                  r_xor      <= 8'd0;
                  r_asm      <= 24'd0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
